pkt_sched: RTL
==============

# pkt_sched

Packet scheduler that owns the `data_bus` driving the packet sequence checker. It arbitrates between `NUM_REQ` requesters and stamps every outgoing word as `{F code, payload, sequence number}`. When a requester is idle it emits filler words so the checker sees a valid sequence on every clock. It watches the checker's `error` output and resynchronises the sequence after a fault.

## Interface
- `BUS_SIZE`, 16: width of `data_bus`.
- `WORD_SIZE`, 4: width of the F-code field and of the sequence field.
- `NUM_REQ`, 4: number of requesters (2..8).
- `RESYNC_CYC`, 4: filler-only cycles after an error (1..15).
- Derived: `PAY_W = BUS_SIZE - 2*WORD_SIZE` (8 at defaults).
- `clk`  in  1  sole clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  NUM_REQ  per-requester request level.
- `payload`  in  NUM_REQ*PAY_W  requester i payload at bits `[i*PAY_W +: PAY_W]`.
- `error`  in  1  checker error flag, registered by the checker.
- `gnt`  out  NUM_REQ  one-hot grant, one-cycle pulse, registered.
- `data_bus`  out  BUS_SIZE  `{F, payload, seq}`, registered.
- `valid`  out  1  high when `data_bus` carries a granted payload; low for filler.
- `err_cnt`  out  8  count of error events, saturating at 255.

## Operation
- F code is all-ones (`{WORD_SIZE{1'b1}}`) on every emitted word, filler included.
- `seq` is a `WORD_SIZE`-bit register.
  - It is placed in `data_bus[WORD_SIZE-1:0]` and advances by 1 on every emitted word.
  - It wraps from `2^WORD_SIZE-1` to 0.
- Payload occupies `data_bus[BUS_SIZE-WORD_SIZE-1:WORD_SIZE]`. Filler payload is 0.
- States:
  - **INIT**: first edge after reset release. Emits filler with `seq=1`, then goes to RUN.
  - **RUN**: each edge, if `req` is nonzero and `error` is low, grants one requester. The granted payload is registered into `data_bus` with `valid=1` and the matching `gnt` bit set. Otherwise filler is emitted.
  - **RESYNC**: entered on any edge where `error=1` in RUN or INIT.
    - The first RESYNC word carries `seq=0`.
    - Filler-only for `RESYNC_CYC` words, then back to RUN.
    - `error` rising again inside RESYNC restarts the count and `seq` from 0.
- `err_cnt` increments on each 0→1 edge of `error`. It saturates at 255.
- A requester must hold `req` and `payload` stable until it sees its `gnt` bit.
- A requester must drop `req` in the cycle `gnt` is high unless it has another word. `req` still high after `gnt` is treated as a new request.

## Timing
- Reset values: `gnt=0`, `data_bus=0`, `valid=0`, `err_cnt=0`, `seq=1`, state INIT.
- Reset asserted mid-operation clears everything in the same cycle, without waiting for a clock edge.
- Latency: `req` sampled on edge n → `gnt`, `valid` and `data_bus` all update on edge n. They are visible for exactly cycle n..n+1.
- Throughput: one word per clock. Back-to-back grants to different or the same requester are allowed.
- `error` and `req` high on the same edge: error wins. No grant is issued and RESYNC is entered.
- `gnt` is never asserted in INIT or RESYNC. `valid` equals the OR of `gnt`.

## Configuration
- `PKT_SCHED_RR_EN` defined:
  - Round-robin arbitration.
  - Search starts at (last granted index + 1) mod `NUM_REQ`.
  - The pointer updates only on a grant and resets to `NUM_REQ-1`, so index 0 wins first.
- Not defined: fixed priority, lowest asserted index wins. No pointer state.

## Test plan
- Reset release, `req=0` for 20 cycles → `data_bus` = 0xF001, 0xF002 … 0xF00F, 0xF000, 0xF001 (wrap), with `valid=0` and `gnt=0` throughout.
- `req[2]=1` for one cycle with payload 0xA5 in RUN at `seq=5` → that edge gives `gnt=4'b0100`, `data_bus=0xFA55`, `valid=1`; next word is filler 0xF006.
- `req=4'b1111` held 8 cycles, payloads 0x10/0x11/0x12/0x13 → with `PKT_SCHED_RR_EN` grants cycle 0,1,2,3,0,1,2,3; without it `gnt=0001` every cycle.
- `error` pulsed one cycle while `req[1]=1` → no `gnt` on that edge; next four words 0xF000, 0xF001, 0xF002, 0xF003 with `valid=0`; `req[1]` granted on the fifth; `err_cnt=1`.
- Second `error` pulse during RESYNC cycle 2 → `seq` restarts at 0, four further filler words, `err_cnt=2`.
- `reset` asserted between clock edges while `gnt=0010` → `gnt`, `valid` and `data_bus` go to 0 before the next edge; after release the first word is 0xF001.

Source files
------------

// File: rtl/pkt_sched.sv
// Packet scheduler: arbitrates requesters onto data_bus as {F, payload, seq}, fills idle cycles, resyncs on error.
// Define PKT_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module pkt_sched #(
    parameter int BUS_SIZE   = 16,
    parameter int WORD_SIZE  = 4,
    parameter int NUM_REQ    = 4,
    parameter int RESYNC_CYC = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQ-1:0]                           req,
    input  logic [NUM_REQ*(BUS_SIZE-2*WORD_SIZE)-1:0]    payload,
    input  logic                                         error,
    output logic [NUM_REQ-1:0]                           gnt,
    output logic [BUS_SIZE-1:0]                          data_bus,
    output logic                                         valid,
    output logic [7:0]                                   err_cnt
);

    // state     | meaning
    // ST_INIT   | first word after reset: filler with seq=1
    // ST_RUN    | grant one requester per clock, filler when idle
    // ST_RESYNC | filler-only words with seq restarted at 0
    localparam int PAY_W = BUS_SIZE - 2*WORD_SIZE;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_RESYNC = 2'd2;

    localparam logic [WORD_SIZE-1:0] F_CODE       = {WORD_SIZE{1'b1}};
    localparam logic [CNT_W-1:0]     CNT_LOAD     = CNT_W'(RESYNC_CYC - 1);
    localparam logic [1:0]           ST_AFTER_ERR = (RESYNC_CYC > 1) ? ST_RESYNC : ST_RUN;

    logic [1:0]           state;
    logic [WORD_SIZE-1:0] seq;
    logic [CNT_W-1:0]     cnt;
    logic                 error_q;

    logic                 win_any;
    logic [IDX_W-1:0]     win_idx;
    logic [PAY_W-1:0]     win_pay;
    logic                 grant_now;

`ifdef PKT_SCHED_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cand;

    // Walk the ring backwards so the requester nearest after rr_ptr is assigned last and wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (grant_now) begin
            rr_ptr <= win_idx;
        end
    end
`else
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_any = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    assign grant_now = (state == ST_RUN) && !error && win_any;
    assign win_pay   = payload[int'(win_idx)*PAY_W +: PAY_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            seq      <= WORD_SIZE'(1);
            cnt      <= '0;
            gnt      <= '0;
            valid    <= 1'b0;
            data_bus <= '0;
        end else begin
            gnt      <= '0;
            valid    <= 1'b0;
            data_bus <= {F_CODE, {PAY_W{1'b0}}, seq};
            seq      <= seq + WORD_SIZE'(1);
            if (error) begin
                // Error wins over any request and restarts the resync window from seq 0.
                data_bus <= {F_CODE, {PAY_W{1'b0}}, {WORD_SIZE{1'b0}}};
                seq      <= WORD_SIZE'(1);
                cnt      <= CNT_LOAD;
                state    <= ST_AFTER_ERR;
            end else begin
                case (state)
                    ST_INIT: begin
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (grant_now) begin
                            gnt      <= NUM_REQ'(1) << win_idx;
                            valid    <= 1'b1;
                            data_bus <= {F_CODE, win_pay, seq};
                        end
                    end
                    ST_RESYNC: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt <= CNT_W'(1)) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        state <= ST_INIT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
            err_cnt <= '0;
        end else begin
            error_q <= error;
            if (error && !error_q && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
